// File: rtl/link_pkg.sv
// Shared definitions for the link delay emulator: timestamp width and bus slicing.
package link_pkg;

   localparam int DEFAULT_DATA_WIDTH = 64;

   // Timestamp width wide enough that the counter period always exceeds the delay,
   // so every stored entry sees age == delay exactly once before wrap-around.
   function automatic int ts_width(input int delay);
      return $clog2(delay + 1) + 1;
   endfunction

   // Low bit of lane `idx` in a flat bus of `width`-bit lanes.
   function automatic int slice_lo(input int idx, input int width);
      return idx * width;
   endfunction

endpackage

// File: rtl/link_delay_channel.sv
// One delay channel: a FIFO whose entries carry an acceptance timestamp and a
// sticky "mature" flag. The head is released once it has aged ROUTER_DELAY cycles.
module link_delay_channel
   import link_pkg::*;
#(
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int ROUTER_DELAY = 53,
   parameter int DEPTH        = 64
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [ts_width(ROUTER_DELAY)-1:0]   now,
   input  logic [DATA_WIDTH-1:0]               in_data,
   input  logic                                in_valid,
   output logic                                in_ready,
   output logic [DATA_WIDTH-1:0]               out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [$clog2(DEPTH):0]              occupancy
);

   localparam int TS_W  = ts_width(ROUTER_DELAY);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [TS_W-1:0]  DELAY_TS = TS_W'(ROUTER_DELAY);
   localparam logic [OCC_W-1:0] FULL_CNT = OCC_W'(DEPTH);

   logic [DATA_WIDTH-1:0] data_mem [DEPTH];
   logic [TS_W-1:0]       ts_mem   [DEPTH];
   logic [DEPTH-1:0]      mature;
   logic [DEPTH-1:0]      ripe;
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [OCC_W-1:0]      count;
   logic [TS_W-1:0]       head_age;
   logic                  empty;
   logic                  push;
   logic                  pop;

   // Ready and occupancy come straight from the registered count, so a pop in
   // the same cycle never opens the door for a push into a full channel.
   assign empty     = (count == '0);
   assign in_ready  = (count != FULL_CNT);
   assign occupancy = count;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;

   // A slot ripens when it is occupied (within count entries of the read pointer)
   // and its age has just reached the delay.
   for (genvar s = 0; s < DEPTH; s++) begin : g_slot
      logic [PTR_W-1:0] rel;
      assign rel     = PTR_W'(s) - rd_ptr;
      assign ripe[s] = ({1'b0, rel} < count) && ((now - ts_mem[s]) == DELAY_TS);
   end

   // Head release: matured earlier, or maturing this very cycle. No path from
   // out_ready or in_valid.
   assign head_age  = now - ts_mem[rd_ptr];
   assign out_valid = !empty && (mature[rd_ptr] || (head_age == DELAY_TS));
   assign out_data  = empty ? '0 : data_mem[rd_ptr];

   // Pointer, count and mature-flag bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         mature <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (pop && !push) count <= count - 1'b1;
         mature <= mature | ripe;
         // NOTE: the later non-blocking write to the same bit wins, so a fresh
         // push always starts its slot un-matured.
         if (push) mature[wr_ptr] <= 1'b0;
      end
   end

   // Beat and timestamp storage.
   // NOTE: storage is not reset; every read is qualified by count, so stale or
   // uninitialised contents never reach the outputs.
   always_ff @(posedge clk) begin
      if (push) begin
         data_mem[wr_ptr] <= in_data;
         ts_mem[wr_ptr]   <= now;
      end
   end

endmodule

// File: rtl/link_delay_array.sv
// Multi-channel link emulator: independent delay channels sharing one free-running
// timestamp counter, plus an all-empty indication.
module link_delay_array
   import link_pkg::*;
#(
   parameter int NUM_LINKS    = 2,
   parameter int DATA_WIDTH   = DEFAULT_DATA_WIDTH,
   parameter int ROUTER_DELAY = 53,
   parameter int DEPTH        = 64
) (
   input  logic                                    clk,
   input  logic                                    reset,
   input  logic [NUM_LINKS*DATA_WIDTH-1:0]         in_data,
   input  logic [NUM_LINKS-1:0]                    in_valid,
   output logic [NUM_LINKS-1:0]                    in_ready,
   output logic [NUM_LINKS*DATA_WIDTH-1:0]         out_data,
   output logic [NUM_LINKS-1:0]                    out_valid,
   input  logic [NUM_LINKS-1:0]                    out_ready,
   output logic [NUM_LINKS*($clog2(DEPTH)+1)-1:0]  occupancy,
   output logic                                    idle
);

   localparam int TS_W  = ts_width(ROUTER_DELAY);
   localparam int OCC_W = $clog2(DEPTH) + 1;

   if (ROUTER_DELAY < 1) begin : g_bad_delay
      $error("link_delay_array: ROUTER_DELAY must be at least 1");
   end
   if (DEPTH < 2) begin : g_bad_depth_small
      $error("link_delay_array: DEPTH must be at least 2");
   end
   if ((DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth_pow2
      $error("link_delay_array: DEPTH must be a power of two");
   end

   logic [TS_W-1:0]      now;
   logic [NUM_LINKS-1:0] chan_empty;

   // Shared timestamp counter, wrapping modulo 2^TS_W.
   always_ff @(posedge clk) begin
      if (reset) now <= '0;
      else       now <= now + 1'b1;
   end

   for (genvar i = 0; i < NUM_LINKS; i++) begin : g_link
      logic [OCC_W-1:0] occ;

      link_delay_channel #(
         .DATA_WIDTH   (DATA_WIDTH),
         .ROUTER_DELAY (ROUTER_DELAY),
         .DEPTH        (DEPTH)
      ) u_chan (
         .clk       (clk),
         .reset     (reset),
         .now       (now),
         .in_data   (in_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
         .in_valid  (in_valid[i]),
         .in_ready  (in_ready[i]),
         .out_data  (out_data[slice_lo(i, DATA_WIDTH) +: DATA_WIDTH]),
         .out_valid (out_valid[i]),
         .out_ready (out_ready[i]),
         .occupancy (occ)
      );

      assign occupancy[slice_lo(i, OCC_W) +: OCC_W] = occ;
      assign chan_empty[i] = (occ == '0);
   end

   assign idle = &chan_empty;

endmodule

// File: doc/link_delay_array.md
# link_delay_array

Synthesisable multi-channel link emulator that inserts a fixed, parametrised transit latency on every valid/ready link between the root hub and its leaves. It replaces direct wiring of the root-hub/leaf 64-bit buses in the full-system benches and FPGA-emulation builds, so multi-FPGA router delay is modelled cycle-accurately on a single device. Each channel is an independent timestamped FIFO that releases a beat exactly `ROUTER_DELAY` cycles after acceptance, with backpressure in both directions.

## Interface
- `NUM_LINKS`, 2: number of independent channels.
- `DATA_WIDTH`, 64: beat width per channel.
- `ROUTER_DELAY`, 53: cycles from input acceptance to earliest output valid; legal range 1..1023.
- `DEPTH`, 64: FIFO entries per channel, power of two, ≥ 2.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `in_data` in `NUM_LINKS*DATA_WIDTH`: channel i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `in_valid` in `NUM_LINKS`: per-channel source valid.
- `in_ready` out `NUM_LINKS`: per-channel ready, equal to not full.
- `out_data` out `NUM_LINKS*DATA_WIDTH`: head beat of each channel.
- `out_valid` out `NUM_LINKS`: head present and matured.
- `out_ready` in `NUM_LINKS`: sink ready.
- `occupancy` out `NUM_LINKS*($clog2(DEPTH)+1)`: entries held per channel.
- `idle` out 1: all channels empty.

## Operation
- Free-running timestamp counter `now`, width `TS_W = $clog2(ROUTER_DELAY+1)+1`, wraps modulo 2^TS_W. One counter is shared by all channels.
- Accept when `in_valid[i] && in_ready[i]`. The beat and `ts = now` are written at the write pointer. The slot's `mature` bit is cleared.
- Per slot, `age = now - ts` (mod 2^TS_W). An occupied slot with `age == ROUTER_DELAY` sets `mature` at the clock edge. Since 2^TS_W > ROUTER_DELAY, every entry passes `age == ROUTER_DELAY` exactly once before the counter wraps, so stalls of any length are safe.
- `out_valid[i]` = head occupied && (head `mature` || head `age == ROUTER_DELAY`).
- `out_data[i]` = head data whenever occupied; otherwise don't-care, driven to 0.
- Pop when `out_valid[i] && out_ready[i]`.
- Ordering: strict FIFO per channel. There is no interaction between channels.
- Full: `in_ready` = 0 and input is held upstream; no beat is ever dropped.
- Simultaneous push and pop when full: the push is refused, because `in_ready` depends only on registered occupancy. When `in_ready` was 1, push and pop in the same cycle keep occupancy unchanged.
- Empty: `out_valid` = 0. A push into an empty channel is not visible at the output until it has matured.
- Throughput: one beat per cycle per channel, sustained when `DEPTH ≥ ROUTER_DELAY + 1`. Smaller DEPTH is legal, but `in_ready` then throttles the source.
- Reset mid-operation: all pointers, occupancy, mature bits and `now` clear on the same edge, and in-flight beats are discarded.
- Elaboration checks: `$error` if ROUTER_DELAY < 1, if DEPTH is not a power of two, or if DEPTH < 2.

## Timing
- Reset values: `in_ready` all 1, `out_valid` all 0, `out_data` 0, `occupancy` 0, `idle` 1, `now` 0. These hold from the first edge with `reset` = 1.
- Latency: a beat accepted in cycle t has `out_valid` = 1 in cycle t+ROUTER_DELAY. This holds when it is head by then; otherwise it is valid in the cycle it becomes head.
- `in_ready`, `occupancy` and `idle` are registered, or decoded from registered state only. `out_valid` is combinational from registered state and `now`, with no path from `out_ready` or `in_valid`.
- `occupancy` and `idle` update on the edge following the handshake.

## Structure
- Shared package: `link_pkg` holds `TS_W` as a function of delay, the default `DATA_WIDTH` = 64, and the `SLICE_VEC`-style slice helper as a function.
- Sub-module `link_delay_channel`: a single-channel FIFO with timestamp and mature arrays. It takes `now` as an input.
- Top level: generate loop over `NUM_LINKS`, plus the shared `now` counter and the `idle` reduction.

## Test plan
- Single beat: ch0 pushes 0xDEAD_BEEF_0000_0001 at cycle 10 with `out_ready` = 1 → `out_valid[0]` first high at cycle 63 (ROUTER_DELAY = 53) and low again at 64. Ch1 stays idle.
- Streaming: 200 back-to-back beats (incrementing data) on both channels with DEPTH = 64 → `in_ready` never drops, data exits in order at 1 beat/cycle, and the first output appears at +53.
- Long stall: fill ch1 with 64 beats while `out_ready[1]` = 0 for 5000 cycles → `in_ready[1]` = 0 and `occupancy` = 64. After release, all 64 beats emerge in order on consecutive cycles with none lost. This exercises `now` wrap.
- Full boundary: ch0 holds 64 beats with `in_valid` held 1. Assert `out_ready` for one cycle → one pop, `in_ready` is 1 on the next cycle, and one push leaves occupancy back at 64.
- Small DEPTH: DEPTH = 8, ROUTER_DELAY = 20, continuous source → in steady state throughput is 8 beats per 21 cycles with no drops.
- Reset mid-flight: reset for 1 cycle while 30 beats are in flight → `occupancy` = 0, `idle` = 1, and no stale beat appears afterward. A fresh beat then shows a 53-cycle latency.
